// File: rtl/cmp_search_ctrl_if.sv
// Comparator link: the search controller drives the B operand, and the comparator answers with three magnitude flags.
interface cmp_search_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] B;
    logic             AgtB;
    logic             AeqB;
    logic             AltB;

    modport master (output B, input AgtB, input AeqB, input AltB);
    modport slave  (input B, output AgtB, output AeqB, output AltB);
endinterface

// File: rtl/cmp_search_ctrl.sv
// Binary-search controller: it probes an external magnitude comparator until it finds the hidden A operand.
// It reports the value found and the number of probe cycles used, and flags any flag combination the comparator cannot legally produce.
module cmp_search_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SW    = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    cmp_search_ctrl_if.master    cmp,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic [SW-1:0]        probes
);

    localparam logic [WIDTH-1:0] ALL1 = '1;
    localparam logic [SW-1:0]    PMAX = '1;

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] b_q, b_n, lo_q, lo_n, hi_q, hi_n, result_n, lo_up, hi_dn;
    logic [SW-1:0]    probes_n;
    logic             err_n, busy_n, done_n;

    // The midpoint is formed from a WIDTH+1-bit sum so that lo+hi cannot overflow.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] c);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, c};
        return s[WIDTH:1];
    endfunction

    assign lo_up = b_q + WIDTH'(1);
    assign hi_dn = b_q - WIDTH'(1);
    assign cmp.B = b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            b_q    <= '0;
            lo_q   <= '0;
            hi_q   <= ALL1;
            result <= '0;
            probes <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            b_q    <= b_n;
            lo_q   <= lo_n;
            hi_q   <= hi_n;
            result <= result_n;
            probes <= probes_n;
            err    <= err_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        b_n      = b_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        result_n = result;
        probes_n = probes;
        err_n    = err;
        case (state)
            IDLE: begin
                b_n = '0;
                if (start) begin
                    lo_n     = '0;
                    hi_n     = ALL1;
                    b_n      = mid('0, ALL1);
                    probes_n = '0;
                    err_n    = 1'b0;
                    state_n  = PROBE;
                end
            end
            PROBE: begin
                probes_n = (probes == PMAX) ? probes : probes + SW'(1);
                state_n  = DONE;
                b_n      = '0;
                // Any outcome that does not narrow the range legally falls through to the error path.
                err_n    = 1'b1;
                case ({cmp.AgtB, cmp.AeqB, cmp.AltB})
                    3'b010: begin
                        result_n = b_q;
                        err_n    = err;
                    end
                    3'b100: begin
                        if (b_q != ALL1 && lo_up <= hi_q) begin
                            lo_n    = lo_up;
                            b_n     = mid(lo_up, hi_q);
                            err_n   = err;
                            state_n = PROBE;
                        end
                    end
                    3'b001: begin
                        if (b_q != '0 && lo_q <= hi_dn) begin
                            hi_n    = hi_dn;
                            b_n     = mid(lo_q, hi_dn);
                            err_n   = err;
                            state_n = PROBE;
                        end
                    end
                    default: ;
                endcase
            end
            DONE: begin
                b_n     = '0;
                state_n = IDLE;
            end
            default: begin
                b_n     = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == PROBE);
        done_n = (state_n == DONE);
    end

endmodule
